// File: rtl/timer_control.sv
// Timer control block: register file, prescaled count-clock generator and clear/interrupt sequencing for an external counter.
// Latency: register writes land on the strobe edge; RData is registered, one cycle after a read strobe; a clear follows its cause by one cycle.
// Backpressure: none. Every access completes in its strobe cycle, and a clear requested during a clear cycle is absorbed.
//
// Ports:
//   Clock, Reset       system clock and asynchronous active-high reset
//   Sel, Write, Addr   one-cycle register strobe, direction and select
//                      (0 TCR, 1 TCMP, 2 TSR, 3 TIER, 4 TCNT read-only)
//   WData, RData       write data and registered read data
//   Irq                level interrupt, (OVF&OVIE)|(CMF&CMIE)
//   CounterClock       generated count clock
//   CounterEdge        count edge mode taken straight from TCR
//   CounterClear       counter clear, high while the FSM sits in CLR
//   TCNT, Overflow     counter value and saturation flag from the counter
//
// BIT_WIDTH must be at least 8, because TCR occupies the low 8 bits of the bus.
module timer_control #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Sel,
    input  logic                 Write,
    input  logic [2:0]           Addr,
    input  logic [BIT_WIDTH-1:0] WData,
    output logic [BIT_WIDTH-1:0] RData,
    output logic                 Irq,
    output logic                 CounterClock,
    output logic [1:0]           CounterEdge,
    output logic                 CounterClear,
    input  logic [BIT_WIDTH-1:0] TCNT,
    input  logic                 Overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CLR  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // register file
    logic                 tcr_en;
    logic [1:0]           tcr_edge;
    logic [2:0]           tcr_cks;
    logic                 tcr_arl;
    logic [BIT_WIDTH-1:0] tcmp;
    logic                 tsr_ovf;
    logic                 tsr_cmf;
    logic                 tier_ovie;
    logic                 tier_cmie;

    // timing and edge-detect state
    logic [6:0]           presc;
    logic                 cclk;
    logic [BIT_WIDTH-1:0] tcnt_q;
    logic                 ovfl_q;

    logic                 bus_wr;
    logic                 bus_rd;
    logic                 tcr_wr;
    logic                 tcmp_wr;
    logic                 tsr_wr;
    logic                 tier_wr;
    logic                 clr_wr;
    logic                 en_eff;
    logic                 cmp_evt;
    logic                 ovf_evt;
    logic                 auto_clr;
    logic [6:0]           presc_mask;
    logic                 tick;
    logic [BIT_WIDTH-1:0] rd_val;

    assign bus_wr  = Sel & Write;
    assign bus_rd  = Sel & ~Write;
    assign tcr_wr  = bus_wr && (Addr == 3'd0);
    assign tcmp_wr = bus_wr && (Addr == 3'd1);
    assign tsr_wr  = bus_wr && (Addr == 3'd2);
    assign tier_wr = bus_wr && (Addr == 3'd3);
    assign clr_wr  = tcr_wr & WData[7];

    // Leaving CLR looks at the enable as it will be after this edge. A
    // disable written during the clear cycle therefore goes straight to
    // IDLE, with no stray RUN cycle between the clear and the stop.
    assign en_eff = tcr_wr ? WData[0] : tcr_en;

    // The compare event needs the counter to move onto TCMP. Rewriting TCMP
    // to the value the counter already holds does not fire it, because the
    // previous count already matches.
    assign cmp_evt  = (TCNT == tcmp) && (tcnt_q != tcmp);
    assign ovf_evt  = Overflow & ~ovfl_q;
    assign auto_clr = tcr_arl & (cmp_evt | ovf_evt);

    // The low CKS bits set: CKS=0 gives an empty mask, so there is a tick every cycle.
    assign presc_mask = ~(7'h7f << tcr_cks);
    assign tick       = (state == RUN) && ((presc & presc_mask) == presc_mask);

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clr_wr)
                    state_nxt = CLR;
                else if (tcr_en)
                    state_nxt = RUN;
            end
            RUN: begin
                if (clr_wr || auto_clr)
                    state_nxt = CLR;
                else if (!tcr_en)
                    state_nxt = IDLE;
            end
            // A single clear cycle. Requests that arrive here are dropped.
            CLR: begin
                state_nxt = en_eff ? RUN : IDLE;
            end
            default: state_nxt = CLR;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= CLR;
        else
            state <= state_nxt;
    end

    // read mux; unused and reserved bits read as zero
    always_comb begin
        rd_val = '0;
        case (Addr)
            3'd0: rd_val[6:0] = {tcr_arl, tcr_cks, tcr_edge, tcr_en};
            3'd1: rd_val      = tcmp;
            3'd2: rd_val[1:0] = {tsr_cmf, tsr_ovf};
            3'd3: rd_val[1:0] = {tier_cmie, tier_ovie};
            3'd4: rd_val      = TCNT;
            default: rd_val   = '0;
        endcase
    end

    // registers, prescaler and count clock
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tcr_en    <= 1'b0;
            tcr_edge  <= 2'b00;
            tcr_cks   <= 3'd0;
            tcr_arl   <= 1'b0;
            tcmp      <= '1;
            tsr_ovf   <= 1'b0;
            tsr_cmf   <= 1'b0;
            tier_ovie <= 1'b0;
            tier_cmie <= 1'b0;
            presc     <= 7'd0;
            cclk      <= 1'b0;
            tcnt_q    <= '0;
            ovfl_q    <= 1'b0;
            RData     <= '0;
        end else begin
            if (tcr_wr) begin
                tcr_en   <= WData[0];
                tcr_edge <= WData[2:1];
                tcr_cks  <= WData[5:3];
                tcr_arl  <= WData[6];
            end
            if (tcmp_wr)
                tcmp <= WData;
            if (tier_wr) begin
                tier_ovie <= WData[0];
                tier_cmie <= WData[1];
            end

            // A set event wins over a simultaneous write-one-to-clear.
            tsr_ovf <= ovf_evt | (tsr_ovf & ~(tsr_wr & WData[0]));
            tsr_cmf <= cmp_evt | (tsr_cmf & ~(tsr_wr & WData[1]));

            presc <= (state == RUN) ? presc + 7'd1 : 7'd0;

            // No tick outside RUN, so the count clock holds its level when stopped.
            if (tick)
                cclk <= ~cclk;

            tcnt_q <= TCNT;
            ovfl_q <= Overflow;

            if (bus_rd)
                RData <= rd_val;
        end
    end

    assign Irq          = (tsr_ovf & tier_ovie) | (tsr_cmf & tier_cmie);
    assign CounterClock = cclk;
    assign CounterEdge  = tcr_edge;
    assign CounterClear = (state == CLR);

endmodule

// File: tb/tb_timer_control.sv
module tb_timer_control;

    logic       Clock;
    logic       Reset;
    logic       Sel;
    logic       Write;
    logic [2:0] Addr;
    logic [7:0] WData;
    logic [7:0] RData;
    logic       Irq;
    logic       CounterClock;
    logic [1:0] CounterEdge;
    logic       CounterClear;
    logic [7:0] TCNT;
    logic       Overflow;

    int vectors;
    int miscompares;

    timer_control #(.BIT_WIDTH(8)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Sel          (Sel),
        .Write        (Write),
        .Addr         (Addr),
        .WData        (WData),
        .RData        (RData),
        .Irq          (Irq),
        .CounterClock (CounterClock),
        .CounterEdge  (CounterEdge),
        .CounterClear (CounterClear),
        .TCNT         (TCNT),
        .Overflow     (Overflow)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Bus helpers. Each is entered 1 time unit after a rising edge and returns 1 time unit after the next one.
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        Sel = 1'b1; Write = 1'b1; Addr = a; WData = d;
        @(posedge Clock); #1;
        Sel = 1'b0; Write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        Sel = 1'b1; Write = 1'b0; Addr = a;
        @(posedge Clock); #1;
        Sel = 1'b0;
    endtask

    task automatic step();
        @(posedge Clock); #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) step();
        vectors++;
        if (CounterClear !== 1'b1) begin miscompares++; $display("FAIL rst_clear_during: got %b want 1", CounterClear); end
        vectors++;
        if (RData !== 8'h00) begin miscompares++; $display("FAIL rst_rdata: got %h want 00", RData); end
        Reset = 1'b0;
        #1;
        vectors++;
        if (CounterClear !== 1'b1) begin miscompares++; $display("FAIL rst_clear_after_release: got %b want 1", CounterClear); end
        step();
        vectors++;
        if ({CounterClear, CounterClock, CounterEdge, Irq} !== 5'b0) begin
            miscompares++; $display("FAIL rst_idle_outputs: got %b want 00000", {CounterClear, CounterClock, CounterEdge, Irq});
        end
        bus_read(3'd1);
        vectors++;
        if (RData !== 8'hFF) begin miscompares++; $display("FAIL rst_tcmp: got %h want ff", RData); end
        bus_read(3'd2);
        vectors++;
        if (RData !== 8'h00) begin miscompares++; $display("FAIL rst_tsr: got %h want 00", RData); end
    endtask

    // Clear written in RUN, then a disable on the next cycle. CKS=0 makes CounterClock toggle every cycle.
    task automatic test_clear_then_disable();
        logic exp_clk [3];
        exp_clk[0] = 1'b0; exp_clk[1] = 1'b1; exp_clk[2] = 1'b0;
        bus_write(3'd0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (CounterClock !== exp_clk[i]) begin miscompares++; $display("FAIL run_clk[%0d]: got %b want %b", i, CounterClock, exp_clk[i]); end
        end
        bus_write(3'd0, 8'h81);
        vectors++;
        if ({CounterClear, CounterClock} !== 2'b11) begin miscompares++; $display("FAIL clr_in_run: got %b want 11", {CounterClear, CounterClock}); end
        bus_write(3'd0, 8'h00);
        vectors++;
        if ({CounterClear, CounterClock} !== 2'b01) begin miscompares++; $display("FAIL clr_then_idle: got %b want 01", {CounterClear, CounterClock}); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({CounterClear, CounterClock} !== 2'b01) begin miscompares++; $display("FAIL idle_hold[%0d]: got %b want 01", i, {CounterClear, CounterClock}); end
        end
        // clear written while idle
        bus_write(3'd0, 8'h80);
        vectors++;
        if (CounterClear !== 1'b1) begin miscompares++; $display("FAIL clr_in_idle: got %b want 1", CounterClear); end
        step();
        vectors++;
        if ({CounterClear, CounterClock} !== 2'b01) begin miscompares++; $display("FAIL clr_idle_exit: got %b want 01", {CounterClear, CounterClock}); end
    endtask

    // EN=1, EDGE=01, CKS=2: the first toggle comes 5 edges after the write, then one toggle every 4 edges.
    task automatic test_clock_div();
        int exp_gap [3];
        logic lvl;
        int n;
        exp_gap[0] = 5; exp_gap[1] = 4; exp_gap[2] = 4;
        bus_write(3'd0, 8'h13);
        vectors++;
        if (CounterEdge !== 2'b01) begin miscompares++; $display("FAIL edge_mode: got %b want 01", CounterEdge); end
        for (int g = 0; g < 3; g++) begin
            lvl = CounterClock;
            n = 0;
            for (int k = 1; k <= 40; k++) begin
                step();
                if (CounterClock !== lvl) begin n = k; break; end
            end
            vectors++;
            if (n !== exp_gap[g]) begin miscompares++; $display("FAIL clk_gap[%0d]: got %0d cycles want %0d (0 = timeout)", g, n, exp_gap[g]); end
        end
    endtask

    task automatic test_compare();
        bus_write(3'd3, 8'h02);
        bus_write(3'd1, 8'h05);
        bus_write(3'd0, 8'h43);
        for (int i = 0; i <= 5; i++) begin
            TCNT = 8'(i);
            step();
            vectors++;
            if ({CounterClear, Irq} !== {2{i == 5}}) begin
                miscompares++; $display("FAIL cmp_tcnt%0d: clear/irq got %b want %b", i, {CounterClear, Irq}, {2{i == 5}});
            end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (CounterClear !== 1'b0) begin miscompares++; $display("FAIL cmp_single_clear[%0d]: got %b want 0", i, CounterClear); end
        end
        bus_read(3'd2);
        vectors++;
        if (RData !== 8'h02) begin miscompares++; $display("FAIL cmp_tsr: got %h want 02", RData); end
        bus_write(3'd2, 8'h02);
        vectors++;
        if (Irq !== 1'b0) begin miscompares++; $display("FAIL cmp_w1c_irq: got %b want 0", Irq); end
        bus_read(3'd2);
        vectors++;
        if (RData !== 8'h00) begin miscompares++; $display("FAIL cmp_w1c_tsr: got %h want 00", RData); end
    endtask

    task automatic test_overflow();
        bus_write(3'd0, 8'h03);
        bus_write(3'd3, 8'h01);
        // The overflow set and a W1C of OVF arrive in the same cycle.
        TCNT = 8'hFF; Overflow = 1'b1;
        Sel = 1'b1; Write = 1'b1; Addr = 3'd2; WData = 8'h01;
        step();
        Sel = 1'b0; Write = 1'b0;
        vectors++;
        if ({CounterClear, Irq} !== 2'b01) begin miscompares++; $display("FAIL ovf_set_wins: clear/irq got %b want 01", {CounterClear, Irq}); end
        bus_read(3'd2);
        vectors++;
        if (RData !== 8'h01) begin miscompares++; $display("FAIL ovf_tsr: got %h want 01", RData); end
        bus_write(3'd2, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({CounterClear, Irq} !== 2'b00) begin miscompares++; $display("FAIL ovf_once[%0d]: clear/irq got %b want 00", i, {CounterClear, Irq}); end
        end
        TCNT = 8'h00; Overflow = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bus_write(3'd1, 8'hFF);
        bus_write(3'd3, 8'h03);
        bus_write(3'd0, 8'h41);
        TCNT = 8'hFF; Overflow = 1'b1;
        step();
        vectors++;
        if ({CounterClear, Irq} !== 2'b11) begin miscompares++; $display("FAIL both_evt: clear/irq got %b want 11", {CounterClear, Irq}); end
        // a clear request issued during the clear cycle is absorbed
        bus_write(3'd0, 8'hC1);
        vectors++;
        if (CounterClear !== 1'b0) begin miscompares++; $display("FAIL absorb_clr: got %b want 0", CounterClear); end
        step();
        vectors++;
        if (CounterClear !== 1'b0) begin miscompares++; $display("FAIL absorb_clr2: got %b want 0", CounterClear); end
        bus_read(3'd2);
        vectors++;
        if (RData !== 8'h03) begin miscompares++; $display("FAIL both_tsr: got %h want 03", RData); end
        bus_write(3'd2, 8'h03);
        vectors++;
        if (Irq !== 1'b0) begin miscompares++; $display("FAIL both_w1c: got %b want 0", Irq); end
        TCNT = 8'h00; Overflow = 1'b0;
        step();
    endtask

    // Reset lands while a clear write and both flag events are pending.
    task automatic test_reset_abort();
        TCNT = 8'hFF; Overflow = 1'b1;
        Sel = 1'b1; Write = 1'b1; Addr = 3'd0; WData = 8'hC1;
        #2 Reset = 1'b1;
        #1;
        vectors++;
        if ({CounterClear, Irq} !== 2'b10) begin miscompares++; $display("FAIL abort_async: clear/irq got %b want 10", {CounterClear, Irq}); end
        Sel = 1'b0; Write = 1'b0; TCNT = 8'h00; Overflow = 1'b0;
        repeat (2) step();
        Reset = 1'b0;
        #1;
        vectors++;
        if (CounterClear !== 1'b1) begin miscompares++; $display("FAIL abort_release: got %b want 1", CounterClear); end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (CounterClear !== 1'b0) begin miscompares++; $display("FAIL abort_no_extra[%0d]: got %b want 0", i, CounterClear); end
        end
        bus_read(3'd2);
        vectors++;
        if ({RData, Irq} !== 9'h000) begin miscompares++; $display("FAIL abort_tsr: got %h/%b want 00/0", RData, Irq); end
        bus_read(3'd0);
        vectors++;
        if (RData !== 8'h00) begin miscompares++; $display("FAIL abort_tcr: got %h want 00", RData); end
    endtask

    task automatic test_registers();
        bus_write(3'd3, 8'hFF);
        bus_read(3'd3);
        vectors++;
        if (RData !== 8'h03) begin miscompares++; $display("FAIL tier_unused: got %h want 03", RData); end
        bus_write(3'd1, 8'hA5);
        bus_read(3'd1);
        vectors++;
        if (RData !== 8'hA5) begin miscompares++; $display("FAIL tcmp_rw: got %h want a5", RData); end
        TCNT = 8'h3C;
        bus_write(3'd4, 8'h55);
        bus_read(3'd4);
        vectors++;
        if (RData !== 8'h3C) begin miscompares++; $display("FAIL tcnt_read: got %h want 3c", RData); end
        bus_read(3'd5);
        vectors++;
        if (RData !== 8'h00) begin miscompares++; $display("FAIL reserved5: got %h want 00", RData); end
        bus_read(3'd1);
        bus_read(3'd7);
        vectors++;
        if (RData !== 8'h00) begin miscompares++; $display("FAIL reserved7: got %h want 00", RData); end
        bus_write(3'd0, 8'hFE);
        vectors++;
        if (CounterEdge !== 2'b11) begin miscompares++; $display("FAIL edge_both: got %b want 11", CounterEdge); end
        step();
        bus_read(3'd0);
        vectors++;
        if (RData !== 8'h7E) begin miscompares++; $display("FAIL tcr_clr_reads0: got %h want 7e", RData); end
        repeat (3) step();
        vectors++;
        if (RData !== 8'h7E) begin miscompares++; $display("FAIL rdata_hold: got %h want 7e", RData); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        Reset = 1'b1; Sel = 1'b0; Write = 1'b0; Addr = 3'd0; WData = 8'h00;
        TCNT = 8'h00; Overflow = 1'b0;
        #1;
        test_reset();
        test_clear_then_disable();
        test_clock_div();
        test_compare();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_registers();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
